// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with a configurable pattern, length, overlap mode and bit window.
// Runs IDLE -> RUN -> DONE; y is a registered match pulse and done marks the end of a run.
module seq_det_ctrl #(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 8,
  localparam int LEN_W = (PAT_W > 1) ? $clog2(PAT_W) : 1,
  localparam int FIL_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic             start,
  input  logic             stop,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [PAT_W-1:0] pat_q, hist, hist_nxt, mask;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] win_q, bit_cnt, bit_nxt;
  logic [FIL_W-1:0] fill, fill_nxt;
  logic             match, win_hit;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (stop || (x_valid && win_hit)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Post-shift view of the history: the match decision uses the bit arriving this edge.
  always_comb begin
    hist_nxt = {hist[PAT_W-2:0], x};
    fill_nxt = (fill == FIL_W'(PAT_W)) ? fill : fill + 1'b1;
    bit_nxt  = bit_cnt + 1'b1;
    mask     = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i <= int'(len_q));
    match    = (int'(fill_nxt) > int'(len_q)) && (((hist_nxt ^ pat_q) & mask) == '0);
    win_hit  = (win_q != '0) && (bit_nxt == win_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b1;
      win_q     <= '0;
      hist      <= '0;
      fill      <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
      y         <= 1'b0;
    end else begin
      y <= 1'b0;
      if (state == IDLE && cfg_we) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        win_q <= cfg_window;
      end
      if (state == IDLE && start) begin
        hist      <= '0;
        fill      <= '0;
        bit_cnt   <= '0;
        match_cnt <= '0;
      end else if (state == RUN && x_valid) begin
        hist    <= hist_nxt;
        bit_cnt <= bit_nxt;
        // Non-overlapping mode demands len fresh bits after every hit.
        fill    <= (match && !ovl_q) ? '0 : fill_nxt;
        if (match) begin
          y <= 1'b1;
          if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus randomized runs against a queue-based model.
module tb_seq_det_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [2:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_window;
  logic             start, stop, x, x_valid;
  logic             busy, y, done;
  logic [CNT_W-1:0] match_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
    .start(start), .stop(stop), .x(x), .x_valid(x_valid),
    .busy(busy), .y(y), .match_cnt(match_cnt), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: recent bits in a queue, run state as 0 idle / 1 run / 2 done.
  bit         hq[$];
  logic [7:0] mpat;
  int         mlen, mfill, mcnt, mbits, mwin, mst;
  bit         movl;

  function automatic bit m_bit(bit b);
    bit hit;
    hq.push_back(b);
    if (hq.size() > PAT_W) void'(hq.pop_front());
    mbits++;
    if (mfill < PAT_W) mfill++;
    hit = (mfill >= mlen);
    for (int i = 0; i < mlen; i++)
      if (hit && hq[hq.size() - 1 - i] != mpat[i]) hit = 0;
    if (hit) begin
      if (mcnt < CMAX) mcnt++;
      if (!movl) mfill = 0;
    end
    return hit;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input bit we, input logic [7:0] p, input int l,
                           input bit o, input int w);
    cfg_we = we; cfg_pattern = p; cfg_len = 3'(l); cfg_overlap = o; cfg_window = 8'(w);
    start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    if (we) begin
      mpat = p; mlen = l + 1; movl = o; mwin = w;
    end else begin
      mpat = 8'h00; mlen = 1; movl = 1'b1; mwin = 0;
    end
    hq.delete(); mfill = 0; mcnt = 0; mbits = 0; mst = 1;
  endtask

  task automatic do_stop();
    x_valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0; mst = 0;
  endtask

  task automatic test_reset();
    logic [3:0] bits;
    logic [3:0] ey;
    rst = 1'b0; start = 1'b1; x_valid = 1'b1; x = 1'b1;
    tick(); tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 1'b0 || match_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b y=%b cnt=%0d, want 0 0 0 0", busy, done, y, match_cnt);
    end
    rst = 1'b1; start = 1'b0; x_valid = 1'b0;
    tick();
    // Default config is pattern 0, length 1: every 0 bit is a match.
    start_run(1'b0, 8'h00, 0, 1'b1, 0);
    bits = 4'b1001; ey = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      x = bits[i]; x_valid = 1'b1;
      tick();
      n_tests++;
      if (y !== ey[i]) begin
        n_fail++;
        $display("FAIL reset_cfg_y bit%0d: y=%b want %b", 3 - i, y, ey[i]);
      end
    end
    do_stop();
    n_tests++;
    if (done !== 1'b1 || match_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL reset_cfg_done: done=%b cnt=%0d want 1 2", done, match_cnt);
    end
    tick();
  endtask

  task automatic test_overlap(input bit ovl);
    logic [4:0] bits;
    bit ey;
    bits = 5'b10101;
    start_run(1'b1, 8'b101, 2, ovl, 0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovl%0b_busy: busy=%b want 1", ovl, busy);
    end
    for (int i = 4; i >= 0; i--) begin
      x = bits[i]; x_valid = 1'b1;
      tick();
      ey = m_bit(bits[i]);
      n_tests++;
      if (y !== ey || match_cnt !== 8'(mcnt)) begin
        n_fail++;
        $display("FAIL ovl%0b_bit%0d: y=%b cnt=%0d want %b %0d", ovl, 5 - i, y, match_cnt, ey, mcnt);
      end
    end
    x_valid = 1'b0;
    tick();
    n_tests++;
    if (y !== 1'b0 || match_cnt !== (ovl ? 8'd2 : 8'd1)) begin
      n_fail++;
      $display("FAIL ovl%0b_final: y=%b cnt=%0d want 0 %0d", ovl, y, match_cnt, ovl ? 2 : 1);
    end
    do_stop();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovl%0b_done: done=%b busy=%b want 1 0", ovl, done, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovl%0b_idle: done=%b busy=%b want 0 0", ovl, done, busy);
    end
  endtask

  task automatic test_window();
    logic [3:0] bits;
    bit ey;
    bits = 4'b1011;
    start_run(1'b1, 8'b101, 2, 1'b1, 4);
    for (int i = 3; i >= 0; i--) begin
      x = $urandom_range(0, 1); x_valid = 1'b0;
      tick();
      n_tests++;
      if (y !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL window_gap%0d: y=%b busy=%b done=%b want 0 1 0", 3 - i, y, busy, done);
      end
      x = bits[i]; x_valid = 1'b1;
      tick();
      ey = m_bit(bits[i]);
      n_tests++;
      if (y !== ey || done !== (i == 0)) begin
        n_fail++;
        $display("FAIL window_bit%0d: y=%b done=%b want %b %b", 4 - i, y, done, ey, i == 0);
      end
    end
    x_valid = 1'b0;
    n_tests++;
    if (match_cnt !== 8'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL window_end: cnt=%0d busy=%b want 1 0", match_cnt, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || match_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL window_after: done=%b busy=%b cnt=%0d want 0 0 1", done, busy, match_cnt);
    end
  endtask

  task automatic test_cfg_in_run();
    logic [4:0] bits;
    bits = 5'b10111;
    start_run(1'b1, 8'b101, 2, 1'b1, 0);
    cfg_we = 1'b1; cfg_pattern = 8'b111; cfg_window = 8'd2; start = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      x = bits[i]; x_valid = 1'b1;
      tick();
      n_tests++;
      if (y !== (i == 2)) begin
        n_fail++;
        $display("FAIL cfgrun_bit%0d: y=%b want %b", 5 - i, y, i == 2);
      end
    end
    cfg_we = 1'b0; start = 1'b0;
    n_tests++;
    if (match_cnt !== 8'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cfgrun_cnt: cnt=%0d busy=%b want 1 1", match_cnt, busy);
    end
    do_stop();
    tick();
  endtask

  task automatic test_rst_midrun();
    logic [4:0] bits;
    bits = 5'b10101;
    start_run(1'b1, 8'b101, 2, 1'b1, 0);
    for (int i = 4; i >= 0; i--) begin
      x = bits[i]; x_valid = 1'b1;
      tick();
    end
    n_tests++;
    if (match_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL rstrun_pre: cnt=%0d want 2", match_cnt);
    end
    rst = 1'b0; stop = 1'b1;
    tick();
    n_tests++;
    if (match_cnt !== '0 || busy !== 1'b0 || done !== 1'b0 || y !== 1'b0) begin
      n_fail++;
      $display("FAIL rstrun_after: cnt=%0d busy=%b done=%b y=%b want 0 0 0 0", match_cnt, busy, done, y);
    end
    rst = 1'b1; stop = 1'b0; x_valid = 1'b0;
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstrun_nodone: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_saturate();
    bit ey;
    start_run(1'b1, 8'b1, 0, 1'b1, 0);
    for (int i = 0; i < 300; i++) begin
      x = 1'b1; x_valid = 1'b1;
      tick();
      ey = m_bit(1'b1);
      n_tests++;
      if (y !== ey || match_cnt !== 8'(mcnt)) begin
        n_fail++;
        $display("FAIL sat_bit%0d: y=%b cnt=%0d want %b %0d", i, y, match_cnt, ey, mcnt);
      end
    end
    do_stop();
    n_tests++;
    if (done !== 1'b1 || match_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_done: done=%b cnt=%0d want 1 255", done, match_cnt);
    end
    tick(); tick();
    n_tests++;
    if (match_cnt !== 8'd255 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_hold: cnt=%0d done=%b want 255 0", match_cnt, done);
    end
  endtask

  task automatic test_random();
    bit ey;
    for (int r = 0; r < 12; r++) begin
      start_run(1'b1, 8'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40));
      for (int cyc = 0; cyc < 300 && mst != 0; cyc++) begin
        x = 1'($urandom); x_valid = ($urandom_range(0, 3) != 0);
        stop = ($urandom_range(0, 59) == 0) || (cyc > 250);
        start = 1'($urandom); cfg_we = 1'($urandom); cfg_pattern = 8'($urandom);
        cfg_len = 3'($urandom); cfg_window = 8'($urandom_range(1, 3));
        tick();
        ey = 1'b0;
        if (mst == 1) begin
          if (x_valid) ey = m_bit(x);
          if (stop || (x_valid && mwin != 0 && mbits == mwin)) mst = 2;
        end else begin
          mst = 0;
        end
        n_tests++;
        if (y !== ey || match_cnt !== 8'(mcnt) || busy !== (mst == 1) || done !== (mst == 2)) begin
          n_fail++;
          $display("FAIL rand_r%0d_c%0d: y=%b cnt=%0d busy=%b done=%b want %b %0d %b %b",
                   r, cyc, y, match_cnt, busy, done, ey, mcnt, mst == 1, mst == 2);
        end
      end
      start = 1'b0; cfg_we = 1'b0; stop = 1'b0; x_valid = 1'b0;
      if (mst != 0) begin
        rst = 1'b0; tick(); rst = 1'b1; mst = 0;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_window = '0; start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
    tick();
    test_reset();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_window();
    test_cfg_in_run();
    test_rst_midrun();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
